mems_spi_arbiter: RTL and testbench

- Shares the single 24-bit SPI master to the quad MEMS DAC between several frame requesters, e.g. the scan sequencer, a DAC config/calibration writer and a debug host.
- Round-robin arbitration, with an optional per-requester lock so that multi-frame bursts (e.g. DAC channels A–D) are never interleaved.
- Drives the master's start/data inputs and watches its busy line.
- Sits between the requesters and the SPI master in the MEMS control path.

---
 rtl/mems_spi_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mems_spi_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mems_spi_arbiter.sv
// mems_spi_arbiter: shares one 24-bit SPI master (quad MEMS DAC) between
// NUM_REQ frame requesters using round-robin arbitration with an optional
// per-requester burst lock.
// Optional feature macro: ARB_TIMEOUT_EN. When defined, a WAIT that outlasts
// TIMEOUT_CYCLES busy cycles is aborted and timeout_err is set (sticky).
module mems_spi_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int FRAME_W        = 24,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         req_lock,
    input  logic [NUM_REQ*FRAME_W-1:0] req_data,
    output logic [NUM_REQ-1:0]         done,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       spi_start,
    output logic [FRAME_W-1:0]         spi_data,
    input  logic                       spi_busy,
    output logic                       timeout_err
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_SETTLE, S_WAIT} state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 spi_start_q, spi_start_d;
    logic [FRAME_W-1:0]   spi_data_q, spi_data_d;
    // rr_ptr_q doubles as the index of the requester currently granted.
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     lock_idx_q, lock_idx_d;
    logic                 lock_vld_q, lock_vld_d;

    logic [FRAME_W-1:0]   frame_arr [NUM_REQ];
    logic                 win_vld;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W:0]       arb_cand;
    logic                 timeout_hit;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_frame
            assign frame_arr[gi] = req_data[gi*FRAME_W +: FRAME_W];
        end
    endgenerate

    // Winner selection: the lock owner only, else first request after rr_ptr.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        arb_cand = '0;
        if (lock_vld_q) begin
            win_vld = req[lock_idx_q];
            win_idx = lock_idx_q;
        end else begin
            for (int i = 1; i <= NUM_REQ; i++) begin
                arb_cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
                if (arb_cand >= (IDX_W+1)'(NUM_REQ)) begin
                    arb_cand = arb_cand - (IDX_W+1)'(NUM_REQ);
                end
                if (!win_vld && req[arb_cand[IDX_W-1:0]]) begin
                    win_vld = 1'b1;
                    win_idx = arb_cand[IDX_W-1:0];
                end
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [12:0] wait_cnt_q, wait_cnt_d;
    logic        timeout_err_q;

    // Count consecutive busy cycles spent in WAIT; cleared everywhere else.
    always_comb begin
        wait_cnt_d = '0;
        if (state_q == S_WAIT && spi_busy) begin
            wait_cnt_d = wait_cnt_q + 13'd1;
        end
    end

    assign timeout_hit = (state_q == S_WAIT) && spi_busy &&
                         (wait_cnt_q == 13'(TIMEOUT_CYCLES - 1));

    // Timeout counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_q | timeout_hit;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Transaction FSM: arbitrate, pulse start, settle one cycle, wait for idle.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        done_d      = '0;
        spi_start_d = 1'b0;
        spi_data_d  = spi_data_q;
        rr_ptr_d    = rr_ptr_q;
        lock_vld_d  = lock_vld_q;
        lock_idx_d  = lock_idx_q;
        case (state_q)
            S_IDLE: begin
                if (!spi_busy && win_vld) begin
                    spi_data_d       = frame_arr[win_idx];
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    rr_ptr_d         = win_idx;
                    state_d          = S_START;
                end
            end
            S_START: begin
                spi_start_d = 1'b1;
                state_d     = S_SETTLE;
            end
            S_SETTLE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!spi_busy) begin
                    done_d[rr_ptr_q] = 1'b1;
                    grant_d          = '0;
                    lock_vld_d       = req_lock[rr_ptr_q];
                    lock_idx_d       = rr_ptr_q;
                    state_d          = S_IDLE;
                end else if (timeout_hit) begin
                    done_d[rr_ptr_q] = 1'b1;
                    grant_d          = '0;
                    lock_vld_d       = 1'b0;
                    state_d          = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; rr_ptr resets so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            done_q      <= '0;
            spi_start_q <= 1'b0;
            spi_data_q  <= '0;
            rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
            lock_vld_q  <= 1'b0;
            lock_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            spi_start_q <= spi_start_d;
            spi_data_q  <= spi_data_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_vld_q  <= lock_vld_d;
            lock_idx_q  <= lock_idx_d;
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign spi_start = spi_start_q;
    assign spi_data  = spi_data_q;

endmodule

// File: tb/tb_mems_spi_arbiter.sv
// Testbench for mems_spi_arbiter: directed scenarios plus randomized frames
// checked against a transaction-level model of the arbitration rules.
module tb_mems_spi_arbiter;
    localparam int N  = 3;
    localparam int FW = 24;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_lock = '0;
    logic [N*FW-1:0] req_data = '0;
    logic [N-1:0]    done;
    logic [N-1:0]    grant;
    logic            spi_start;
    logic [FW-1:0]   spi_data;
    logic            spi_busy;
    logic            timeout_err;

    int   total = 0;
    int   bad = 0;
    int   busy_len = 0;
    int   busy_cnt = 0;
    logic force_busy = 1'b0;

    // Reference model state: round-robin pointer and lock owner.
    int   rr_m = N - 1;
    bit   lock_v_m = 1'b0;
    int   owner_m = 0;

    mems_spi_arbiter #(
        .NUM_REQ(N),
        .FRAME_W(FW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_lock(req_lock),
        .req_data(req_data),
        .done(done),
        .grant(grant),
        .spi_start(spi_start),
        .spi_data(spi_data),
        .spi_busy(spi_busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // SPI master model: busy for busy_len cycles after it samples a start.
    always @(posedge clk) begin
        if (rst) busy_cnt <= 0;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
        else if (spi_start) busy_cnt <= busy_len;
    end
    assign spi_busy = force_busy | (busy_cnt != 0);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r);
        int c;
        if (lock_v_m) return owner_m;
        for (int i = 1; i <= N; i++) begin
            c = (rr_m + i) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        req_lock = '0;
        force_busy = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_outputs", {done, grant, spi_start, spi_data, timeout_err}, 32'h0);
        rst = 1'b0;
        rr_m = N - 1;
        lock_v_m = 1'b0;
        owner_m = 0;
    endtask

    // One frame for requester k; gap = cycles from spi_start to done.
    task automatic expect_frame(input int k, input int exp_gap, input int mid_req,
                                input int exp_lat, input bit is_to);
        int n;
        bit hold_ok;
        logic [FW-1:0] d;
        d = req_data[k*FW +: FW];
        n = 0;
        while (grant == '0 && n < 100) begin
            @(negedge clk);
            n++;
            if (n == 1) check("done_single", 32'(done), 32'h0);
        end
        check("grant", 32'(grant), 32'(1) << k);
        if (exp_lat >= 0) check("arb_latency", 32'(n), 32'(exp_lat));
        check("spi_data", 32'(spi_data), 32'(d));
        check("start_with_grant", 32'(spi_start), 32'h0);
        @(negedge clk);
        check("spi_start_pulse", 32'(spi_start), 32'h1);
        n = 0;
        hold_ok = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) check("spi_start_single", 32'(spi_start), 32'h0);
            if (n == 2 && mid_req >= 0) req = N'(mid_req);
            if (done == '0 && 32'(grant) != (32'(1) << k)) hold_ok = 1'b0;
        end while (done == '0 && n < 5000);
        check("done_gap", 32'(n), 32'(exp_gap));
        check("done_index", 32'(done), 32'(1) << k);
        check("grant_cleared", 32'(grant), 32'h0);
        check("grant_hold", 32'(hold_ok), 32'h1);
        check("timeout_err", 32'(timeout_err), 32'(is_to));
        $display("frame: req=%0d data=%06h gap=%0d", k, d, n);
        rr_m = k;
        owner_m = k;
        lock_v_m = is_to ? 1'b0 : req_lock[k];
    endtask

    initial begin
        int seq3[5];
        int n;
        seq3 = '{0, 0, 0, 0, 1};

        // Basic frame after reset.
        do_reset();
        req_data[23:0] = 24'h3F0015;
        req = 3'b001;
        busy_len = 10;
        expect_frame(0, 12, -1, 1, 1'b0);
        req = '0;

        // Plain round robin, then an idle gap with no requests.
        do_reset();
        req_data = {24'hC00002, 24'hB00001, 24'hA00000};
        req = 3'b111;
        for (int i = 0; i < 6; i++) begin
            busy_len = 3 + i;
            expect_frame(i % 3, busy_len + 2, -1, 1, 1'b0);
        end
        req = '0;
        repeat (4) @(negedge clk);
        check("idle_no_grant", 32'(grant), 32'h0);
        req = 3'b111;
        busy_len = 2;
        expect_frame(0, 4, -1, 1, 1'b0);
        req = '0;

        // Burst lock held by requester 0 for three frames.
        do_reset();
        req_data = {24'h333333, 24'h222222, 24'h111111};
        req = 3'b011;
        req_lock = 3'b001;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) req_lock = 3'b000;
            busy_len = 1 + i;
            expect_frame(seq3[i], busy_len + 2, -1, 1, 1'b0);
        end
        req = '0;

        // Requester 2 drops req mid-frame; next grant wraps to 0.
        do_reset();
        req_data = {24'h0CC0CC, 24'h0BB0BB, 24'h0AA0AA};
        req = 3'b100;
        busy_len = 6;
        expect_frame(2, 8, 3, 1, 1'b0);
        busy_len = 0;
        expect_frame(0, 2, -1, 1, 1'b0);
        req = '0;

        // Randomized frames against the model.
        do_reset();
        for (int it = 0; it < 30; it++) begin
            logic [N-1:0] r;
            int k;
            r = N'($urandom_range(1, 7));
            if (lock_v_m) r[owner_m] = 1'b1;
            req = r;
            req_lock = N'($urandom_range(0, 7)) & N'($urandom_range(0, 7));
            for (int j = 0; j < N; j++) req_data[j*FW +: FW] = FW'($urandom);
            busy_len = $urandom_range(0, 12);
            k = pick(r);
            expect_frame(k, busy_len + 2, -1, 1, 1'b0);
        end
        req = '0;

        // Reset while in SETTLE.
        do_reset();
        req_data = {24'h777777, 24'h666666, 24'h555555};
        req = 3'b010;
        busy_len = 4;
        n = 0;
        while (grant == '0 && n < 100) begin @(negedge clk); n++; end
        check("settle_grant", 32'(grant), 32'h2);
        @(negedge clk);
        check("settle_start", 32'(spi_start), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_settle", {done, grant, spi_start, spi_data, timeout_err}, 32'h0);
        rst = 1'b0;
        rr_m = N - 1;
        lock_v_m = 1'b0;
        req = 3'b011;
        expect_frame(0, 6, -1, 1, 1'b0);
        req = '0;

        // Foreign busy after reset blocks arbitration; then a stuck master.
        do_reset();
        req_data = {24'h0, 24'h0, 24'h5A5A5A};
        req = 3'b001;
        force_busy = 1'b1;
        repeat (5) @(negedge clk);
        check("foreign_busy_blocks", 32'(grant), 32'h0);
        force_busy = 1'b0;
        busy_len = 1000;
`ifdef ARB_TIMEOUT_EN
        expect_frame(0, TO + 1, -1, 1, 1'b1);
        req = '0;
        repeat (20) @(negedge clk);
        check("timeout_sticky", 32'(timeout_err), 32'h1);
`else
        n = 0;
        while (grant == '0 && n < 100) begin @(negedge clk); n++; end
        repeat (40) @(negedge clk);
        check("wait_forever_grant", 32'(grant), 32'h1);
        check("wait_forever_done", 32'(done), 32'h0);
        check("no_timeout_err", 32'(timeout_err), 32'h0);
`endif
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
